// File: rtl/trig_period_meter_pkg.sv
// Shared types for the trigger period meter: measurement FSM state encoding.
// Code 2'd3 is unused and recovers to IDLE in the FSM default branch.
package trig_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_MEASURING = 2'd2
    } state_t;

endpackage

// File: rtl/trig_period_meter_edge_detect.sv
// Rising-edge detector: one-cycle combinational pulse from IN and its registered history.
// Zero latency on PULSE_OUT; no backpressure, IN is sampled every cycle.
module edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic IN,
    output logic PULSE_OUT
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = IN;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign PULSE_OUT = IN & ~hist_q;

endmodule

// File: rtl/trig_period_meter.sv
// Measures CLK cycles between successive TRIG_IN rising edges, saturating with an OVERFLOW flag.
// Capture visible one cycle after the sampling edge; no backpressure, unread captures are overwritten and flagged MISSED.
module trig_period_meter
    import trig_period_meter_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE_IN,
    input  logic                    TRIG_IN,
    input  logic                    READ_ACK,
    output logic [PERIOD_WIDTH-1:0] PERIOD,
    output logic                    VALID,
    output logic                    OVERFLOW,
    output logic                    MISSED,
    output logic                    BUSY
);

    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = {PERIOD_WIDTH{1'b1}};

    logic                    trig_event;
    logic                    capture;
    state_t                  state_q,    state_d;
    logic [PERIOD_WIDTH-1:0] counter_q,  counter_d;
    logic                    ovf_q,      ovf_d;
    logic [PERIOD_WIDTH-1:0] period_q,   period_d;
    logic                    valid_q,    valid_d;
    logic                    overflow_q, overflow_d;
    logic                    missed_q,   missed_d;
    logic                    busy_q,     busy_d;

    edge_detect u_edge_detect (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN        (TRIG_IN),
        .PULSE_OUT (trig_event)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        ovf_d     = ovf_q;
        capture   = 1'b0;

        // Disable wins over any event seen in the same cycle.
        if (!ENABLE_IN) begin
            state_d   = ST_IDLE;
            counter_d = '0;
            ovf_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    counter_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_event) begin
                        counter_d = CNT_ONE;
                        ovf_d     = 1'b0;
                        state_d   = ST_MEASURING;
                    end
                end
                ST_MEASURING: begin
                    if (trig_event) begin
                        capture   = 1'b1;
                        counter_d = CNT_ONE;
                        ovf_d     = 1'b0;
                    end else begin
                        if (counter_q != CNT_MAX) begin
                            counter_d = counter_q + CNT_ONE;
                        end
                        ovf_d = ovf_q | (counter_d == CNT_MAX);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                    ovf_d     = 1'b0;
                end
            endcase
        end

        period_d   = period_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        missed_d   = missed_q;
        if (capture) begin
            period_d   = counter_q;
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            // An acknowledge in the capture cycle consumes the old data, so nothing is lost.
            missed_d   = READ_ACK ? 1'b0 : (missed_q | valid_q);
        end else if (READ_ACK) begin
            valid_d  = 1'b0;
            missed_d = 1'b0;
        end

        busy_d = (state_d == ST_MEASURING);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            counter_q  <= '0;
            ovf_q      <= 1'b0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            missed_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            ovf_q      <= ovf_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            missed_q   <= missed_d;
            busy_q     <= busy_d;
        end
    end

    assign PERIOD   = period_q;
    assign VALID    = valid_q;
    assign OVERFLOW = overflow_q;
    assign MISSED   = missed_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_trig_period_meter.sv
// Bench for trig_period_meter: directed scenarios plus randomized traffic against a timestamp-based reference model.
module tb_trig_period_meter;

    localparam int W    = 4;
    localparam int MAXV = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         trig;
    logic         ack;
    logic [W-1:0] period;
    logic         valid;
    logic         ovf;
    logic         missed;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 armed, 2 measuring; intervals from event timestamps.
    int           cyc = 0;
    bit           m_hist;
    int           phase;
    int           t_last;
    logic [W-1:0] e_period;
    bit           e_valid;
    bit           e_ovf;
    bit           e_missed;
    bit           e_busy;

    always #5 clk = ~clk;

    trig_period_meter #(.PERIOD_WIDTH(W)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .ENABLE_IN (en),
        .TRIG_IN   (trig),
        .READ_ACK  (ack),
        .PERIOD    (period),
        .VALID     (valid),
        .OVERFLOW  (ovf),
        .MISSED    (missed),
        .BUSY      (busy)
    );

    task automatic model_reset();
        m_hist   = 1'b0;
        phase    = 0;
        t_last   = 0;
        e_period = '0;
        e_valid  = 1'b0;
        e_ovf    = 1'b0;
        e_missed = 1'b0;
        e_busy   = 1'b0;
    endtask

    task automatic step(input bit i_en, input bit i_trig, input bit i_ack);
        bit ev;
        bit cap;
        int d;
        en   = i_en;
        trig = i_trig;
        ack  = i_ack;
        @(posedge clk);
        cyc++;
        ev     = i_trig && !m_hist;
        m_hist = i_trig;
        cap    = 1'b0;
        d      = 0;
        if (!i_en) begin
            phase = 0;
        end else if (phase == 0) begin
            phase = 1;
        end else if (phase == 1) begin
            if (ev) begin
                t_last = cyc;
                phase  = 2;
            end
        end else if (ev) begin
            cap    = 1'b1;
            d      = cyc - t_last;
            t_last = cyc;
        end
        if (cap) begin
            e_period = (d > MAXV) ? W'(MAXV) : W'(d);
            e_ovf    = (d >= MAXV);
            e_missed = i_ack ? 1'b0 : (e_missed | e_valid);
            e_valid  = 1'b1;
        end else if (i_ack) begin
            e_valid  = 1'b0;
            e_missed = 1'b0;
        end
        e_busy = (phase == 2);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = 1'b0;
        trig = 1'b0;
        ack  = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if (period !== '0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", ovf); end
        n_checks++;
        if (missed !== 1'b0) begin n_fail++; $display("FAIL reset_missed: got %b want 0", missed); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0);
    endtask

    task automatic test_basic();
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_first_pulse_valid: got %b want 0", valid); end
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({period, valid, ovf} !== {4'd5, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL basic_period: got p=%0d v=%b o=%b want p=5 v=1 o=0", period, valid, ovf); end
    endtask

    task automatic test_overflow();
        step(1, 0, 1);
        step(1, 1, 0);
        for (int i = 0; i < 19; i++) step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({period, ovf} !== {4'd15, 1'b1})
            begin n_fail++; $display("FAIL ovf_saturate: got p=%0d o=%b want p=15 o=1", period, ovf); end
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({period, ovf} !== {4'd6, 1'b0})
            begin n_fail++; $display("FAIL ovf_recover: got p=%0d o=%b want p=6 o=0", period, ovf); end
    endtask

    task automatic test_missed();
        step(1, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({period, valid, missed} !== {4'd7, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL missed_first: got p=%0d v=%b m=%b want p=7 v=1 m=0", period, valid, missed); end
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({period, missed} !== {4'd9, 1'b1})
            begin n_fail++; $display("FAIL missed_overwrite: got p=%0d m=%b want p=9 m=1", period, missed); end
        step(1, 0, 1);
        n_checks++;
        if ({period, valid, missed} !== {4'd9, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL missed_ack: got p=%0d v=%b m=%b want p=9 v=0 m=0", period, valid, missed); end
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 1);
        n_checks++;
        if ({period, valid, missed} !== {4'd3, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL capture_with_ack: got p=%0d v=%b m=%b want p=3 v=1 m=0", period, valid, missed); end
    endtask

    task automatic test_level();
        step(1, 0, 1);
        step(1, 1, 0);
        step(1, 1, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 0);
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL level_single_event: got v=%b want 0", valid); end
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({period, valid} !== {4'd12, 1'b1})
            begin n_fail++; $display("FAIL level_period: got p=%0d v=%b want p=12 v=1", period, valid); end
        step(1, 0, 0);
    endtask

    task automatic test_enable_drop();
        step(1, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        n_checks++;
        if ({valid, busy} !== 2'b00)
            begin n_fail++; $display("FAIL endrop_no_capture: got v=%b b=%b want v=0 b=0", valid, busy); end
        step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({valid, busy} !== 2'b01)
            begin n_fail++; $display("FAIL endrop_rearm: got v=%b b=%b want v=0 b=1", valid, busy); end
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({period, valid} !== {4'd4, 1'b1})
            begin n_fail++; $display("FAIL endrop_period: got p=%0d v=%b want p=4 v=1", period, valid); end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({period, valid, ovf, missed, busy} !== '0)
            begin n_fail++; $display("FAIL async_reset: got p=%0d v=%b o=%b m=%b b=%b want all 0", period, valid, ovf, missed, busy); end
        model_reset();
        rst = 1'b0;
        step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({valid, busy} !== 2'b01)
            begin n_fail++; $display("FAIL async_first_event: got v=%b b=%b want v=0 b=1", valid, busy); end
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if ({period, valid} !== {4'd3, 1'b1})
            begin n_fail++; $display("FAIL async_second_event: got p=%0d v=%b want p=3 v=1", period, valid); end
    endtask

    task automatic test_random();
        logic [W+3:0] got;
        logic [W+3:0] exp;
        int           density;
        bit           r_en;
        bit           r_trig;
        bit           r_ack;
        density = 4;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) density = ($urandom_range(0, 1) == 0) ? 4 : 24;
            r_en   = ($urandom_range(0, 39) != 0);
            r_trig = ($urandom_range(0, density - 1) == 0);
            r_ack  = ($urandom_range(0, 7) == 0);
            step(r_en, r_trig, r_ack);
            got = {period, valid, ovf, missed, busy};
            exp = {e_period, e_valid, e_ovf, e_missed, e_busy};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got p=%0d v=%b o=%b m=%b b=%b want p=%0d v=%b o=%b m=%b b=%b",
                         cyc, period, valid, ovf, missed, busy, e_period, e_valid, e_ovf, e_missed, e_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_missed();
        test_level();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
